// File: rtl/return_address_stack_pkg.sv
// Shared fetch-unit types for the return address stack.
// Optional build macro: RSD_RAS_TOP_REPAIR_EN adds the top-of-stack address
// to the recovery checkpoint so a wrong-path overwrite of the top entry can be
// undone on misprediction recovery.
package FetchUnitTypes;

    localparam int DECODE_WIDTH    = 2;
    localparam int PC_WIDTH        = 32;
    localparam int INSN_BYTE_WIDTH = 4;

    localparam int RAS_ENTRY_NUM       = 8;
    localparam int RAS_INDEX_BIT_WIDTH = $clog2(RAS_ENTRY_NUM);
    localparam int RAS_COUNT_BIT_WIDTH = $clog2(RAS_ENTRY_NUM + 1);
    localparam int DECODE_LANE_INDEX_BIT_WIDTH =
        (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;

    typedef logic [PC_WIDTH-1:0]                    PC_Path;
    typedef logic [DECODE_LANE_INDEX_BIT_WIDTH-1:0] DecodeLaneIndexPath;
    typedef logic [RAS_INDEX_BIT_WIDTH-1:0]         RAS_IndexPath;
    typedef logic [RAS_COUNT_BIT_WIDTH-1:0]         RAS_CountPath;

    // Stack state carried with each predicted branch so the backend can
    // rewind the stack after a misprediction.
    typedef struct packed {
`ifdef RSD_RAS_TOP_REPAIR_EN
        PC_Path       topAddr;
`endif
        RAS_IndexPath ptr;
        RAS_CountPath count;
    } RAS_CheckpointPath;

    // Return address pushed for a call: the instruction after the call.
    function automatic PC_Path NextInsnAddr(input PC_Path pc);
        return pc + PC_Path'(INSN_BYTE_WIDTH);
    endfunction

endpackage

// File: rtl/return_address_stack_ras_entry_array.sv
// Return address storage: DEPTH registers, one write port, one
// asynchronous read port.
module ras_entry_array
    import FetchUnitTypes::*;
#(
    parameter int DEPTH = RAS_ENTRY_NUM
)(
    input  logic         clk,
    input  logic         writeEnable,
    input  RAS_IndexPath writeIndex,
    input  PC_Path       writeData,
    input  RAS_IndexPath readIndex,
    output PC_Path       readData
);

    PC_Path entry [DEPTH];

    // Write the selected entry on a push or repair.
    // NOTE: storage has no reset; validity is tracked by the stack count.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            entry[writeIndex] <= writeData;
        end
    end

    assign readData = entry[readIndex];

endmodule

// File: rtl/return_address_stack.sv
// Return address stack for decode-stage return prediction.
// Scans the decode lanes, acts on the first call/return, and exposes a
// checkpoint of the stack state for misprediction recovery.
// Optional build macro: RSD_RAS_TOP_REPAIR_EN (checkpoint also restores the
// top entry on recovery).
// DEPTH must match RAS_ENTRY_NUM, which sizes the checkpoint fields.
module return_address_stack
    import FetchUnitTypes::*;
#(
    parameter int DEPTH = RAS_ENTRY_NUM,
    parameter int WIDTH = DECODE_WIDTH
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [WIDTH-1:0]  insnValid,
    input  logic [WIDTH-1:0]  isCall,
    input  logic [WIDTH-1:0]  isReturn,
    input  PC_Path            pc [WIDTH],
    input  logic              recoverValid,
    input  RAS_CheckpointPath recoverCkpt,
    output logic              retPredValid,
    output PC_Path            retPredAddr,
    output DecodeLaneIndexPath opLane,
    output RAS_CheckpointPath ckptOut
);

    localparam RAS_CountPath FULL_COUNT = RAS_CountPath'(DEPTH);

    RAS_IndexPath       ptr, nextPtr;
    RAS_CountPath       count, nextCount;
    logic               selFound, scanStop;
    DecodeLaneIndexPath selLane;
    logic               selCall, selReturn;
    PC_Path             selPc, topEntry;
    logic               writeEnable;
    RAS_IndexPath       writeIndex;
    PC_Path             writeData;

    // Find the first call/return lane before the first invalid lane.
    // NOTE: blocking assignments here build the priority chain in loop order.
    always_comb begin
        selFound = 1'b0;
        selLane  = '0;
        scanStop = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!scanStop) begin
                if (!insnValid[i]) begin
                    scanStop = 1'b1;
                end else if (isCall[i] || isReturn[i]) begin
                    selFound = 1'b1;
                    selLane  = DecodeLaneIndexPath'(i);
                    scanStop = 1'b1;
                end
            end
        end
    end

    assign selCall   = selFound && isCall[selLane];
    assign selReturn = selFound && isReturn[selLane];
    assign selPc     = pc[selLane];

    // Next pointer/count and entry write: recovery beats stall beats the op.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        nextPtr     = ptr;
        nextCount   = count;
        writeEnable = 1'b0;
        writeIndex  = ptr;
        writeData   = NextInsnAddr(selPc);
        if (recoverValid) begin
            nextPtr   = recoverCkpt.ptr;
            nextCount = recoverCkpt.count;
`ifdef RSD_RAS_TOP_REPAIR_EN
            writeEnable = 1'b1;
            writeIndex  = recoverCkpt.ptr;
            writeData   = recoverCkpt.topAddr;
`endif
        end else if (!stall && selFound) begin
            if (selCall && selReturn) begin
                // Pop-then-push replaces the top in place.
                writeEnable = 1'b1;
                if (count == '0) begin
                    nextCount = RAS_CountPath'(1);
                end
            end else if (selCall) begin
                // Pointer wraps naturally, overwriting the oldest entry at full.
                nextPtr     = ptr + 1'b1;
                writeEnable = 1'b1;
                writeIndex  = ptr + 1'b1;
                if (count != FULL_COUNT) begin
                    nextCount = count + 1'b1;
                end
            end else if (count != '0) begin
                nextPtr   = ptr - 1'b1;
                nextCount = count - 1'b1;
            end
        end
    end

    // Stack pointer and occupancy registers.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= nextPtr;
            count <= nextCount;
        end
    end

    // Writes are blocked during reset so an in-flight push is discarded.
    ras_entry_array #(
        .DEPTH(DEPTH)
    ) entryArray (
        .clk        (clk),
        .writeEnable(writeEnable && rst),
        .writeIndex (writeIndex),
        .writeData  (writeData),
        .readIndex  (ptr),
        .readData   (topEntry)
    );

    // Prediction and checkpoint outputs, all from registered state.
    always_comb begin
        retPredValid  = rst && !recoverValid && selReturn && (count != '0);
        retPredAddr   = topEntry;
        opLane        = rst ? selLane : '0;
        ckptOut       = '0;
        ckptOut.ptr   = ptr;
        ckptOut.count = count;
`ifdef RSD_RAS_TOP_REPAIR_EN
        ckptOut.topAddr = topEntry;
`endif
    end

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: fixed vector table, directed
// overflow/recovery/reset sequences and random stimulus against a model.
`timescale 1ns/1ps
module tb_return_address_stack;
    import FetchUnitTypes::*;

    localparam int D = RAS_ENTRY_NUM;
    localparam int W = DECODE_WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [W-1:0]      insnValid, isCall, isReturn;
    PC_Path            pc [W];
    logic              recoverValid;
    RAS_CheckpointPath recoverCkpt;
    logic              retPredValid;
    PC_Path            retPredAddr;
    DecodeLaneIndexPath opLane;
    RAS_CheckpointPath ckptOut;

    int vectors = 0;
    int miscompares = 0;

    return_address_stack dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .insnValid   (insnValid),
        .isCall      (isCall),
        .isReturn    (isReturn),
        .pc          (pc),
        .recoverValid(recoverValid),
        .recoverCkpt (recoverCkpt),
        .retPredValid(retPredValid),
        .retPredAddr (retPredAddr),
        .opLane      (opLane),
        .ckptOut     (ckptOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: circular stack by the rules ----------
    PC_Path mMem [D];
    int     mPtr = 0;
    int     mCount = 0;

    function automatic void modelSelect(output bit found, output int lane);
        found = 0;
        lane  = 0;
        for (int i = 0; i < W; i++) begin
            if (!insnValid[i]) break;
            if (isCall[i] || isReturn[i]) begin
                found = 1;
                lane  = i;
                break;
            end
        end
    endfunction

    function automatic void modelUpdate();
        bit f;
        int l;
        modelSelect(f, l);
        if (recoverValid) begin
            mPtr   = int'(recoverCkpt.ptr);
            mCount = int'(recoverCkpt.count);
`ifdef RSD_RAS_TOP_REPAIR_EN
            mMem[recoverCkpt.ptr] = recoverCkpt.topAddr;
`endif
        end else if (!stall && f) begin
            if (isCall[l] && isReturn[l]) begin
                mMem[mPtr] = pc[l] + INSN_BYTE_WIDTH;
                if (mCount == 0) mCount = 1;
            end else if (isCall[l]) begin
                mPtr = (mPtr + 1) % D;
                mMem[mPtr] = pc[l] + INSN_BYTE_WIDTH;
                mCount = (mCount + 1 > D) ? D : mCount + 1;
            end else if (mCount != 0) begin
                mPtr = (mPtr + D - 1) % D;
                mCount = mCount - 1;
            end
        end
    endfunction

    task automatic compareModel(input string name);
        bit f;
        int l;
        bit expValid;
        modelSelect(f, l);
        expValid = f && isReturn[l] && (mCount != 0) && !recoverValid;
        check({name, ".retPredValid"}, 64'(retPredValid), 64'(expValid));
        check({name, ".opLane"}, 64'(opLane), 64'(f ? l : 0));
        if (expValid) check({name, ".retPredAddr"}, 64'(retPredAddr), 64'(mMem[mPtr]));
        check({name, ".ptr"}, 64'(ckptOut.ptr), 64'(mPtr));
        check({name, ".count"}, 64'(ckptOut.count), 64'(mCount));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic setIdle();
        stall = 0;
        recoverValid = 0;
        recoverCkpt = '0;
        insnValid = '0;
        isCall = '0;
        isReturn = '0;
        for (int i = 0; i < W; i++) pc[i] = '0;
    endtask

    task automatic setLanes(input logic [1:0] v, input logic [1:0] c, input logic [1:0] r,
                            input PC_Path p0, input PC_Path p1);
        insnValid = v;
        isCall = c;
        isReturn = r;
        pc[0] = p0;
        pc[1] = p1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic doReset();
        setIdle();
        setLanes(2'b11, 2'b00, 2'b10, 32'h0, 32'h0);
        rst = 0;
        #2;
        check("reset.retPredValid", 64'(retPredValid), 64'(0));
        check("reset.opLane", 64'(opLane), 64'(0));
        check("reset.ptr", 64'(ckptOut.ptr), 64'(0));
        check("reset.count", 64'(ckptOut.count), 64'(0));
        @(posedge clk);
        @(negedge clk);
        mPtr = 0;
        mCount = 0;
        setIdle();
        rst = 1;
        #2;
        check("postReset.retPredValid", 64'(retPredValid), 64'(0));
        check("postReset.opLane", 64'(opLane), 64'(0));
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] v, c, r;
        PC_Path     p0, p1;
        logic       stl;
        logic       expValid;
        PC_Path     expAddr;
        int         expLane;
        int         expPtr;
        int         expCount;
    } TableVec;

    TableVec tbl [16];
    RAS_CheckpointPath ck;

    initial begin
        rst = 1;
        setIdle();
        #1;

        // ---- overflow: 9 calls then 9 returns (also fills every entry) ----
        doReset();
        for (int k = 1; k <= 9; k++) begin
            setLanes(2'b01, 2'b01, 2'b00, PC_Path'(k * 32'h100), 32'h0);
            #2 compareModel("overflowCall");
            tick();
        end
        setIdle();
        #2;
        check("overflow.fullCount", 64'(ckptOut.count), 64'(8));
        check("overflow.wrapPtr", 64'(ckptOut.ptr), 64'(1));
        for (int k = 1; k <= 9; k++) begin
            setLanes(2'b01, 2'b00, 2'b01, 32'h0, 32'h0);
            #2;
            check("overflowRet.valid", 64'(retPredValid), 64'(k <= 8));
            if (k <= 8) check("overflowRet.addr", 64'(retPredAddr), 64'((10 - k) * 32'h100 + 4));
            compareModel("overflowRet");
            tick();
        end

        // ---- table-driven single-cycle behaviour ----
        tbl[0]  = '{2'b01, 2'b01, 2'b00, 32'h1000, 32'h0,    0, 0, 0,        0, 0, 0};
        tbl[1]  = '{2'b11, 2'b00, 2'b10, 32'h0,    32'h1010, 0, 1, 32'h1004, 1, 1, 1};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 0, 0};
        tbl[3]  = '{2'b01, 2'b00, 2'b01, 32'h0,    32'h0,    0, 0, 0,        0, 0, 0};
        tbl[4]  = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 0, 0};
        tbl[5]  = '{2'b11, 2'b01, 2'b10, 32'h2000, 32'h0,    0, 0, 0,        0, 0, 0};
        tbl[6]  = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 1, 1};
        tbl[7]  = '{2'b10, 2'b10, 2'b00, 32'h0,    32'h3000, 0, 0, 0,        0, 1, 1};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 1, 1};
        tbl[9]  = '{2'b01, 2'b00, 2'b01, 32'h0,    32'h0,    0, 1, 32'h2004, 0, 1, 1};
        tbl[10] = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 0, 0};
        tbl[11] = '{2'b01, 2'b01, 2'b01, 32'h4000, 32'h0,    0, 0, 0,        0, 0, 0};
        tbl[12] = '{2'b01, 2'b00, 2'b01, 32'h0,    32'h0,    0, 1, 32'h4004, 0, 0, 1};
        tbl[13] = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 7, 0};
        tbl[14] = '{2'b01, 2'b01, 2'b00, 32'h5000, 32'h0,    1, 0, 0,        0, 7, 0};
        tbl[15] = '{2'b00, 2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 7, 0};
        doReset();
        for (int i = 0; i < 16; i++) begin
            setLanes(tbl[i].v, tbl[i].c, tbl[i].r, tbl[i].p0, tbl[i].p1);
            stall = tbl[i].stl;
            #2;
            check($sformatf("tbl%0d.retPredValid", i), 64'(retPredValid), 64'(tbl[i].expValid));
            if (tbl[i].expValid) check($sformatf("tbl%0d.retPredAddr", i), 64'(retPredAddr), 64'(tbl[i].expAddr));
            check($sformatf("tbl%0d.opLane", i), 64'(opLane), 64'(tbl[i].expLane));
            check($sformatf("tbl%0d.ptr", i), 64'(ckptOut.ptr), 64'(tbl[i].expPtr));
            check($sformatf("tbl%0d.count", i), 64'(ckptOut.count), 64'(tbl[i].expCount));
            tick();
        end
        setIdle();

        // ---- recovery sequence ----
        doReset();
        setLanes(2'b01, 2'b01, 2'b00, 32'hA000, 32'h0); #2 compareModel("rec.callA"); tick();
        setLanes(2'b01, 2'b01, 2'b00, 32'hB000, 32'h0); #2 compareModel("rec.callB"); tick();
        setIdle();
        #2;
        check("rec.ckptPtr", 64'(ckptOut.ptr), 64'(2));
        check("rec.ckptCount", 64'(ckptOut.count), 64'(2));
        ck = '0;
        ck.ptr = 2;
        ck.count = 2;
`ifdef RSD_RAS_TOP_REPAIR_EN
        ck.topAddr = 32'hB004;
`endif
        setLanes(2'b01, 2'b00, 2'b01, 32'h0, 32'h0);    #2 compareModel("rec.pop");   tick();
        setLanes(2'b01, 2'b01, 2'b00, 32'hC000, 32'h0); #2 compareModel("rec.callC"); tick();
        setLanes(2'b01, 2'b01, 2'b00, 32'hD000, 32'h0); #2 compareModel("rec.callD"); tick();
        setLanes(2'b01, 2'b01, 2'b00, 32'hE000, 32'h0);
        recoverValid = 1;
        recoverCkpt = ck;
        #2 compareModel("rec.recoverCall");
        tick();
        setIdle();
        #2;
        check("rec.restoredPtr", 64'(ckptOut.ptr), 64'(2));
        check("rec.restoredCount", 64'(ckptOut.count), 64'(2));
        setLanes(2'b01, 2'b00, 2'b01, 32'h0, 32'h0);
        recoverValid = 1;
        recoverCkpt = ck;
        #2;
        check("rec.forcedInvalid", 64'(retPredValid), 64'(0));
        tick();
        setIdle();
        setLanes(2'b01, 2'b00, 2'b01, 32'h0, 32'h0);
        #2;
        check("rec.topValid", 64'(retPredValid), 64'(1));
`ifdef RSD_RAS_TOP_REPAIR_EN
        check("rec.topAddr", 64'(retPredAddr), 64'(32'hB004));
`else
        check("rec.topAddr", 64'(retPredAddr), 64'(32'hC004));
`endif
        compareModel("rec.popAfter");
        tick();
        // recovery beats stall
        setIdle();
        stall = 1;
        recoverValid = 1;
        recoverCkpt = '0;
        recoverCkpt.ptr = 5;
        recoverCkpt.count = 3;
        #2 compareModel("rec.stallRecover");
        tick();
        setIdle();
        #2;
        check("rec.stallRecoverPtr", 64'(ckptOut.ptr), 64'(5));
        check("rec.stallRecoverCount", 64'(ckptOut.count), 64'(3));

        // ---- random stimulus against the model ----
        for (int n = 0; n < 400; n++) begin
            setIdle();
            setLanes(2'($urandom), 2'($urandom), 2'($urandom),
                     PC_Path'($urandom) & ~PC_Path'(3), PC_Path'($urandom) & ~PC_Path'(3));
            stall = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                recoverValid = 1;
                recoverCkpt = '0;
                recoverCkpt.ptr = RAS_IndexPath'($urandom_range(0, D - 1));
                recoverCkpt.count = RAS_CountPath'($urandom_range(0, D));
`ifdef RSD_RAS_TOP_REPAIR_EN
                recoverCkpt.topAddr = PC_Path'($urandom);
`endif
            end
            #2 compareModel("random");
            tick();
        end

        // ---- reset asserted mid-operation discards the push ----
        setIdle();
        setLanes(2'b01, 2'b01, 2'b00, 32'h7000, 32'h0);
        #2 rst = 0;
        #1;
        check("midReset.ptr", 64'(ckptOut.ptr), 64'(0));
        check("midReset.count", 64'(ckptOut.count), 64'(0));
        check("midReset.opLane", 64'(opLane), 64'(0));
        @(posedge clk);
        @(negedge clk);
        mPtr = 0;
        mCount = 0;
        setIdle();
        rst = 1;
        #2;
        check("midReset.afterPtr", 64'(ckptOut.ptr), 64'(0));
        check("midReset.afterCount", 64'(ckptOut.count), 64'(0));
        check("midReset.afterValid", 64'(retPredValid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of stack entries, power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default DECODE_WIDTH: number of decode lanes examined per cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port stall, input, 1 bit: freezes all state updates.
REQ-006 SHALL have port insnValid, input, WIDTH x 1 bit: lane holds a valid decoded insn.
REQ-007 SHALL have port isCall, input, WIDTH x 1 bit: JAL or JALR with rd set to x1 or x5.
REQ-008 SHALL have port isReturn, input, WIDTH x 1 bit: JALR with rs1 set to x1 or x5 and rs1 not equal to rd.
REQ-009 SHALL have port pc, input, WIDTH x PC_Path: lane PC.
REQ-010 SHALL have port recoverValid, input, 1 bit: backend misprediction recovery.
REQ-011 SHALL have port recoverCkpt, input, RAS_CheckpointPath: state to restore.
REQ-012 SHALL have port retPredValid, output, 1 bit: retPredAddr is usable.
REQ-013 SHALL have port retPredAddr, output, PC_Path: predicted return target.
REQ-014 SHALL have port opLane, output, DecodeLaneIndexPath: lane acted upon this cycle.
REQ-015 SHALL have port ckptOut, output, RAS_CheckpointPath: state before this cycle's operation, carried with the branch.

Function
REQ-016 SHALL scan lanes 0..WIDTH-1 in order and stop at the first lane with insnValid=0.
- The selected lane is the first scanned lane with isCall=1 or isReturn=1.
- Only the selected lane operates in a cycle; later call/return lanes are ignored because the decode resolver flushes them.
REQ-017 SHALL perform a push when the selected lane is a call only:
- write pc+INSN_BYTE_WIDTH at ptr+1 modulo DEPTH;
- advance ptr;
- count=min(count+1, DEPTH).
REQ-018 SHALL perform a pop when the selected lane is a return only:
- drive retPredAddr=entry[ptr] and retPredValid=(count!=0);
- when count!=0, set ptr=ptr-1 modulo DEPTH and count=count-1;
- when count=0, change no state.
REQ-019 SHALL perform a pop-then-push when the selected lane has both isCall and isReturn:
- predict entry[ptr];
- overwrite entry[ptr] with pc+INSN_BYTE_WIDTH;
- leave ptr and count unchanged; if count was 0, count becomes 1.
REQ-020 SHALL compute retPredValid, retPredAddr and opLane combinationally from registered state; retPredValid=0 whenever no return is selected.
REQ-021 SHALL make state updates visible from the next clock edge; a push is readable in the following cycle.
REQ-022 SHALL overwrite the oldest entry silently on push at full (count=DEPTH) through pointer wrap-around.
REQ-023 SHALL suppress all updates while stall=1; combinational outputs stay driven.
REQ-024 SHALL, on recoverValid=1, load ptr and count from recoverCkpt; recovery has priority over a same-cycle push or pop and over stall, and retPredValid is forced to 0 in that cycle.
REQ-025 SHALL drive ckptOut with the current ptr and count (plus the top entry when REQ-029 applies) every cycle.

Reset
REQ-026 SHALL, while rst=0, clear ptr and count to 0 asynchronously; entries are not required to be cleared.
REQ-027 SHALL keep retPredValid=0 and opLane=0 during and immediately after reset; reset asserted mid-operation discards any in-flight push.

Configuration
REQ-028 SHALL restore only ptr and count on recovery when RSD_RAS_TOP_REPAIR_EN is undefined; RAS_CheckpointPath then carries no address field.
REQ-029 SHALL, when RSD_RAS_TOP_REPAIR_EN is defined, add topAddr (entry[ptr]) to RAS_CheckpointPath and write recoverCkpt.topAddr back to entry[recoverCkpt.ptr] on recovery.

Structure
REQ-030 SHALL place RAS_ENTRY_NUM, RAS_IndexPath, RAS_CountPath and the RAS_CheckpointPath struct in FetchUnitTypes.
REQ-031 SHALL keep the lane scan in this module and use one sub-module, ras_entry_array: DEPTH x PC_Path registers with 1 write port and 1 read port.

Verification
REQ-032 SHALL test a single push: lane0 call at pc=0x1000, then lane1 return next cycle -> retPredValid=1, retPredAddr=0x1004, opLane=1, count returns to 0.
REQ-033 SHALL test overflow: 9 calls at pc=0x100,0x200,...,0x900 with DEPTH=8, then 9 returns -> targets 0x904..0x204, then retPredValid=0 on the 9th return.
REQ-034 SHALL test lane priority: call in lane0 and return in lane1 in the same cycle -> only the push happens, retPredValid=0, opLane=0.
REQ-035 SHALL test recovery: capture ckptOut (ptr=2, count=2), push twice, then recoverValid=1 together with a call -> next cycle ptr=2, count=2, the call is ignored, and with the macro defined the top entry is restored.
REQ-036 SHALL test a gap: stall=1 with a call, or insnValid[0]=0 with a call in lane1 -> no state change.
REQ-037 SHALL test pop on empty: return with count=0 -> retPredValid=0 and ptr unchanged.
